// File: rtl/uart_line_buffer.sv
// uart_line_buffer: line-buffered uart echo (rx handshake in, tx handshake out, line_len/overflow/busy status)
module uart_line_buffer #(
  parameter int DEPTH = 64,
  parameter int ADDR_W = 6,
  parameter logic [7:0] EOL = 8'h0D,
  parameter logic [7:0] BS = 8'h08
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        data_rx,
  input  logic              ready_rx,
  output logic              done_rx,
  output logic [7:0]        data_tx,
  output logic              ready_tx,
  input  logic              done_tx,
  output logic [ADDR_W:0]   line_len,
  output logic              overflow,
  output logic              busy
);
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  logic [0:0] state;
  logic [7:0] mem [DEPTH];
  logic [ADDR_W:0] wr_ptr, rd_ptr, wr_inc, rd_inc;
  logic rx_armed, accept;
  assign accept = (state == FILL) && ready_rx && rx_armed;
  assign wr_inc = wr_ptr + ONE;
  assign rd_inc = rd_ptr + ONE;
  assign busy = (state == DRAIN);
  always_ff @(posedge clk)
    if (rst_n && accept && data_rx != BS) mem[wr_ptr[ADDR_W-1:0]] <= data_rx;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FILL;
      wr_ptr <= '0;
      rd_ptr <= '0;
      done_rx <= 1'b0;
      ready_tx <= 1'b0;
      data_tx <= '0;
      line_len <= '0;
      overflow <= 1'b0;
      rx_armed <= 1'b1;
    end else begin
      done_rx <= accept;
      rx_armed <= !ready_rx || (rx_armed && !accept);
      if (state == FILL) begin
        if (accept) begin
          overflow <= 1'b0;
          if (data_rx == BS) begin
            if (wr_ptr != '0) begin
              wr_ptr <= wr_ptr - ONE;
              line_len <= wr_ptr - ONE;
            end
          end else begin
            wr_ptr <= wr_inc;
            line_len <= wr_inc;
            if (data_rx == EOL || wr_inc == FULL) begin
              state <= DRAIN;
              rd_ptr <= '0;
              overflow <= (data_rx != EOL);
            end
          end
        end
      end else if (ready_tx && done_tx) begin
        ready_tx <= 1'b0;
        rd_ptr <= rd_inc;
        if (rd_inc == line_len) begin
          state <= FILL;
          wr_ptr <= '0;
        end
      end else if (!ready_tx && !done_tx) begin
        data_tx <= mem[rd_ptr[ADDR_W-1:0]];
        ready_tx <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_line_buffer.sv
// tb_uart_line_buffer: directed self-checking bench for uart_line_buffer
module tb_uart_line_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] data_rx = '0;
  logic ready_rx = 1'b0;
  logic done_rx;
  logic [7:0] data_tx;
  logic ready_tx;
  logic done_tx = 1'b0;
  logic [6:0] line_len;
  logic overflow;
  logic busy;
  int n_cmp = 0;
  int n_err = 0;
  int acks = 0;
  int a0;
  uart_line_buffer dut (
    .clk(clk), .rst_n(rst_n), .data_rx(data_rx), .ready_rx(ready_rx), .done_rx(done_rx),
    .data_tx(data_tx), .ready_tx(ready_tx), .done_tx(done_tx), .line_len(line_len),
    .overflow(overflow), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (done_rx) acks <= acks + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input int hold);
    @(negedge clk);
    data_rx = b;
    ready_rx = 1'b1;
    repeat (hold) @(negedge clk);
    ready_rx = 1'b0;
  endtask
  task automatic expect_tx(input string tag, input logic [7:0] b);
    int t = 0;
    while (!ready_tx && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_rdy"}, ready_tx, 1);
    check(tag, data_tx, b);
    done_tx = 1'b1;
    @(negedge clk);
    done_tx = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready_tx", ready_tx, 0);
    check("rst_done_rx", done_rx, 0);
    check("rst_data_tx", data_tx, 0);
    check("rst_line_len", line_len, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    // basic line
    a0 = acks;
    send(8'h41, 3); send(8'h42, 3); send(8'h0D, 3);
    check("basic_acks", acks - a0, 3);
    check("basic_busy", busy, 1);
    check("basic_len", line_len, 3);
    expect_tx("basic_0", 8'h41); expect_tx("basic_1", 8'h42); expect_tx("basic_2", 8'h0D);
    check("basic_idle", busy, 0);
    check("basic_len_after", line_len, 3);
    // backspace editing
    a0 = acks;
    send(8'h41, 2); send(8'h42, 2); send(8'h08, 2); send(8'h43, 2); send(8'h0D, 2);
    check("bs_acks", acks - a0, 5);
    check("bs_len", line_len, 3);
    expect_tx("bs_0", 8'h41); expect_tx("bs_1", 8'h43); expect_tx("bs_2", 8'h0D);
    check("bs_idle", busy, 0);
    // leading backspace
    a0 = acks;
    send(8'h08, 1); send(8'h0D, 1);
    @(negedge clk);
    check("lbs_acks", acks - a0, 2);
    check("lbs_len", line_len, 1);
    expect_tx("lbs_0", 8'h0D);
    check("lbs_idle", busy, 0);
    // overflow at DEPTH without EOL
    for (int i = 0; i < 63; i++) send(8'h55, 1);
    check("ovf_pre", overflow, 0);
    check("ovf_pre_len", line_len, 63);
    send(8'h55, 1);
    check("ovf_set", overflow, 1);
    check("ovf_len", line_len, 64);
    check("ovf_busy", busy, 1);
    for (int i = 0; i < 64; i++) expect_tx($sformatf("ovf_%0d", i), 8'h55);
    check("ovf_idle", busy, 0);
    check("ovf_sticky", overflow, 1);
    send(8'h41, 1);
    check("ovf_clear", overflow, 0);
    check("ovf_next_len", line_len, 1);
    send(8'h0D, 1);
    expect_tx("ovf_next_0", 8'h41); expect_tx("ovf_next_1", 8'h0D);
    // hold-off during drain
    send(8'h5A, 1); send(8'h0D, 1);
    @(negedge clk);
    a0 = acks;
    data_rx = 8'h58;
    ready_rx = 1'b1;
    expect_tx("hold_0", 8'h5A);
    check("hold_no_ack", acks - a0, 0);
    expect_tx("hold_1", 8'h0D);
    check("hold_fill", busy, 0);
    check("hold_no_ack_edge", acks - a0, 0);
    @(negedge clk);
    check("hold_accepted_len", line_len, 1);
    repeat (4) @(negedge clk);
    check("hold_once", acks - a0, 1);
    ready_rx = 1'b0;
    send(8'h0D, 1);
    expect_tx("hold_2", 8'h58); expect_tx("hold_3", 8'h0D);
    // reset mid-drain
    send(8'h41, 1); send(8'h42, 1); send(8'h0D, 1);
    expect_tx("rstd_0", 8'h41);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstd_ready_tx", ready_tx, 0);
    check("rstd_busy", busy, 0);
    check("rstd_len", line_len, 0);
    check("rstd_overflow", overflow, 0);
    send(8'h51, 1); send(8'h0D, 1);
    check("rstd_new_len", line_len, 2);
    expect_tx("rstd_1", 8'h51); expect_tx("rstd_2", 8'h0D);
    check("rstd_idle", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_line_buffer.md
Name: uart_line_buffer

Overview:
- Sits between the uart core's receive handshake (data_rx/ready_rx/done_rx) and its transmit handshake (data_tx/ready_tx/done_tx).
- Collects received bytes into an on-chip line buffer until end-of-line, then replays the whole line to the transmitter.
- Turns the byte-by-byte echo path into a line-buffered echo with backspace editing and overflow protection.
- Clocked by the uart clock domain.

Parameters:
- DEPTH, 64, line buffer capacity in bytes; must be a power of 2.
- ADDR_W, 6, log2(DEPTH).
- EOL, 8'h0D, end-of-line byte; it is stored and replayed.
- BS, 8'h08, backspace byte; it is never stored.

Ports:
- clk  input  1  uart clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- data_rx  input  8  received byte from uart; valid while ready_rx=1.
- ready_rx  input  1  uart has a received byte pending.
- done_rx  output  1  one-cycle acknowledge; byte consumed.
- data_tx  output  8  byte to transmit; stable while ready_tx=1.
- ready_tx  output  1  byte pending for uart transmitter.
- done_tx  input  1  uart has taken data_tx.
- line_len  output  ADDR_W+1  bytes in current/last line, including EOL.
- overflow  output  1  sticky flag: current line hit DEPTH without EOL.
- busy  output  1  1 while in DRAIN.

Behaviour:
- Interface decisions: one clock, clk; reset rst_n is synchronous, active-low.
- Reset (rst_n=0 at an edge):
  - state=FILL; wr_ptr=0; rd_ptr=0.
  - done_rx=0, ready_tx=0, data_tx=0, line_len=0, overflow=0, busy=0.
  - rx_armed=1.
  - Buffer contents are don't-care.
  - Reset mid-DRAIN abandons the line; ready_tx drops at the next edge.
- rx_armed:
  - Cleared on each accept.
  - Set on any cycle where ready_rx=0.
  - Purpose: a byte held on ready_rx across several cycles is accepted exactly once.
- FILL state (busy=0):
  - Accept when ready_rx=1 and rx_armed=1.
  - done_rx=1 on the following cycle only; never asserted in DRAIN.
  - Accepted byte == BS: if wr_ptr>0, decrement wr_ptr; if wr_ptr=0, ignore it. The byte is acknowledged in both cases.
  - Accepted byte == EOL: write buffer[wr_ptr], line_len=wr_ptr+1, go to DRAIN.
  - Any other byte: write buffer[wr_ptr], wr_ptr+1.
    - If the new count equals DEPTH: line_len=DEPTH, overflow=1, go to DRAIN.
  - overflow clears when the first byte of the next line is accepted.
  - line_len tracks wr_ptr live during FILL.
- DRAIN state (busy=1):
  - rd_ptr=0 on entry.
  - The cycle after entry: data_tx=buffer[rd_ptr] (registered read), ready_tx=1.
  - done_tx=1 while ready_tx=1:
    - Next edge: ready_tx=0, rd_ptr+1.
    - If rd_ptr+1 == line_len: go to FILL, wr_ptr=0.
    - Otherwise reload data_tx and reassert ready_tx once done_tx=0. Minimum one-cycle gap between bytes.
  - done_tx while ready_tx=0 is ignored.
  - Bytes arriving on ready_rx during DRAIN are not acknowledged; they are held off until FILL.
- Simultaneous events:
  - DRAIN→FILL and ready_rx=1 on the same cycle: the byte is accepted on the first FILL cycle, not the transition cycle.
  - BS and full on the same line: BS accepted first; full is evaluated after the pointer update.
- Widths: wr_ptr and rd_ptr are ADDR_W+1 bits, so a count of DEPTH is representable. Memory is indexed by the low ADDR_W bits.
- Latency: EOL accept to first ready_tx is 2 cycles.

Test Plan:
- Basic line: send "AB\r" (41,42,0D), each ready_rx held 3 cycles.
  - Exactly 3 done_rx pulses.
  - Then ready_tx presents 41, 42, 0D in order; line_len=3; busy returns to 0 after the third done_tx.
- Backspace: send 41,42,08,43,0D.
  - Replay 41,43,0D; line_len=3; 5 done_rx pulses.
- Leading backspace: send 08,0D.
  - Replay 0D only; line_len=1.
- Overflow: DEPTH=64, send 64×8'h55 with no EOL.
  - overflow=1 after the 64th accept; replay 64×55; line_len=64.
  - overflow=0 after the first byte of the next line.
- Hold-off: assert ready_rx with 8'h58 during DRAIN of "Z\r".
  - No done_rx until DRAIN ends; 58 is then accepted once, on the first FILL cycle.
- Reset mid-DRAIN: drop rst_n for 1 cycle after the first done_tx.
  - Next cycle: ready_tx=0, busy=0, line_len=0, overflow=0.
  - A new line "Q\r" then replays correctly.
